// File: rtl/ixc_assign_fifo.sv
// ----------------------------------------------------------------------------
// ixc_assign_fifo
//
// Elastic replacement for a plain bitwise assign. A WIDTH-bit word on R is
// carried to L through a DEPTH-entry circular buffer. Both sides use
// valid/ready handshakes, so the assignment can cross a boundary where the
// consumer stalls without losing data. With BYPASS=1 an empty buffer passes
// the word straight through in the same cycle.
//
// Parameters:
//   WIDTH  - data bits per word (>= 1)
//   DEPTH  - buffer entries (>= 1, need not be a power of two)
//   BYPASS - 0: registered, 1-cycle minimum latency; 1: fall-through when empty
//   CW     - width of count, derived from DEPTH; do not override
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   R        in   source word
//   r_valid  in   R is valid
//   r_ready  out  block accepts R this cycle (registered-derived only)
//   L        out  destination word (head entry, R on fall-through, else 0)
//   l_valid  out  L is valid
//   l_ready  in   consumer accepts L this cycle
//   count    out  number of entries held
//   ovf      out  sticky: r_valid seen while r_ready was low
// ----------------------------------------------------------------------------
module ixc_assign_fifo #(
    parameter int WIDTH  = 5,
    parameter int DEPTH  = 2,
    parameter int BYPASS = 0,
    parameter int CW     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] R,
    input  logic             r_valid,
    output logic             r_ready,
    output logic [WIDTH-1:0] L,
    output logic             l_valid,
    input  logic             l_ready,
    output logic [CW-1:0]    count,
    output logic             ovf
);

    localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam bit            FALL     = (BYPASS != 0);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             ovf_q;

    logic empty;
    logic push;
    logic pop;
    logic fall_through;
    logic do_write;
    logic do_read;

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PW'(1);
    endfunction

    // r_ready looks only at registered state, never at l_ready, so a full
    // buffer refuses a push even in a cycle where it is being drained.
    always_comb begin
        empty   = (cnt == '0);
        r_ready = !rst && (cnt != FULL_CNT);
        l_valid = !empty || (FALL && r_valid && !rst);

        if (!empty) begin
            L = mem[rd_ptr];
        end else if (FALL) begin
            L = R;
        end else begin
            L = '0;
        end

        push = r_valid && r_ready;
        pop  = l_valid && l_ready;

        // A pop while empty can only be a fall-through, and then the word is
        // consumed directly from R and never written into storage.
        fall_through = FALL && empty && push && pop;
        do_write     = push && !fall_through;
        do_read      = pop && !empty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_write) begin
                mem[wr_ptr] <= R;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_read) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_write, do_read})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (r_valid && !r_ready) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign count = cnt;
    assign ovf   = ovf_q;

endmodule
